// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch: PC handshake, single-outstanding memory read, small in-order output buffer.
// Out-of-range addresses bypass memory and enqueue a NOP tagged with the offending PC.
module instr_fetch #(
  parameter int DATA_W = 32,
  parameter int PC_MAX = 24,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  output logic              mem_req,
  output logic [7:0]        mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [DATA_W-1:0] instr,
  output logic [7:0]        instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              wrap,
  output logic              range_err
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [7:0] PC_LAST = 8'(PC_MAX);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state, state_d;
  logic [7:0]        pc_q;
  logic [CW-1:0]     count;
  logic [CW-1:0]     wr_idx;
  logic              handshake, in_range, push, pop;
  logic [7:0]        push_pc;
  logic [DATA_W-1:0] push_data;
  logic              prev_vld;
  logic [7:0]        prev_pc;
  logic [DATA_W-1:0] buf_data [DEPTH];
  logic [7:0]        buf_pc   [DEPTH];
  logic              buf_vld  [DEPTH];

  assign in_range  = (pc_in <= PC_LAST);
  assign handshake = pc_valid && pc_ready;
  assign pop       = buf_vld[0] && instr_ready;
  assign wr_idx    = count - CW'(pop);

  always_comb begin
    state_d   = state;
    pc_ready  = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    push      = 1'b0;
    push_pc   = pc_q;
    push_data = mem_rdata;
    case (state)
      IDLE: begin
        pc_ready = rst_n && (count < CW'(DEPTH));
        if (pc_valid && pc_ready) begin
          if (in_range) begin
            state_d = REQ;
          end else begin
            push      = 1'b1;
            push_pc   = pc_in;
            push_data = '0;
          end
        end
      end
      REQ: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        state_d  = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc_q      <= '0;
      count     <= '0;
      wrap      <= 1'b0;
      range_err <= 1'b0;
      prev_vld  <= 1'b0;
      prev_pc   <= '0;
    end else begin
      state <= state_d;
      count <= count + CW'(push) - CW'(pop);
      if (handshake && in_range) pc_q <= pc_in;
      wrap <= handshake && prev_vld && (prev_pc == PC_LAST) && (pc_in == '0);
      if (handshake) begin
        prev_vld <= 1'b1;
        prev_pc  <= pc_in;
      end
      if (handshake && !in_range) range_err <= 1'b1;
    end
  end

  // Shift-register buffer: slot 0 is always the head, so outputs come straight from flops.
  for (genvar g = 0; g < DEPTH; g++) begin : g_buf
    logic [DATA_W-1:0] up_data;
    logic [7:0]        up_pc;
    logic              up_vld;
    if (g < DEPTH - 1) begin : g_mid
      assign up_data = buf_data[g+1];
      assign up_pc   = buf_pc[g+1];
      assign up_vld  = buf_vld[g+1];
    end else begin : g_last
      assign up_data = '0;
      assign up_pc   = '0;
      assign up_vld  = 1'b0;
    end
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        buf_data[g] <= '0;
        buf_pc[g]   <= '0;
        buf_vld[g]  <= 1'b0;
      end else if (push && (wr_idx == CW'(g))) begin
        buf_data[g] <= push_data;
        buf_pc[g]   <= push_pc;
        buf_vld[g]  <= 1'b1;
      end else if (pop) begin
        buf_data[g] <= up_data;
        buf_pc[g]   <= up_pc;
        buf_vld[g]  <= up_vld;
      end
    end
  end

  assign instr       = buf_data[0];
  assign instr_pc    = buf_pc[0];
  assign instr_valid = buf_vld[0];

endmodule
